// File: rtl/fetch_stage_ctrl_pkg.sv
// Shared types and constants for the fetch stage: FSM state encoding,
// the bubble instruction and the sequential PC increment.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    MISS = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0
  localparam int          PC_STEP   = 4;

  // A fetch target must be word aligned; the low two bits flag a bad redirect.
  function automatic logic misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_stage_ctrl_if.sv
// Instruction-memory request/response bus seen by the fetch stage.
// The fetch stage (master) presents the address; memory answers in the same cycle.
interface fetch_stage_ctrl_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic            imem_valid;

  modport master (
    output imem_addr,
    input  imem_rdata,
    input  imem_valid
  );

  modport slave (
    input  imem_addr,
    output imem_rdata,
    output imem_valid
  );
endinterface

// File: rtl/fetch_stage_ctrl_sat_counter.sv
// Up-counter that sticks at its all-ones maximum instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/fetch_stage_ctrl.sv
// Fetch stage: PC register, instruction-memory request and the IF/ID register,
// steered by the hazard unit's stall/flush controls and the EX branch redirect.
module fetch_stage_ctrl #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(fetch_pkg::NOP_INSTR),
  parameter int              CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pc_write,
  input  logic             if_id_write,
  input  logic             if_flush,
  input  logic             branch_taken,
  input  logic [XLEN-1:0]  branch_target,
  fetch_stage_ctrl_if.master imem,
  output logic [XLEN-1:0]  if_id_instr,
  output logic [XLEN-1:0]  if_id_pc,
  output logic             if_id_valid,
  output logic [1:0]       fetch_state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             misalign_err
);
  import fetch_pkg::*;

  fetch_state_t    state_q;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] ipc_q, ipc_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;

  logic squash;
  logic live;
  logic stall_inc;

  // A redirect always squashes IF/ID, so it shares the flush path.
  assign squash    = if_flush | branch_taken;
  assign live      = (state_q != BOOT);
  assign stall_inc = !if_id_write && !squash;

  always_comb begin
    pc_d = pc_q;
    if (branch_taken) begin
      pc_d = {branch_target[XLEN-1:2], 2'b00};
    end else if (pc_write && imem.imem_valid && live) begin
      pc_d = pc_q + XLEN'(PC_STEP);
    end
  end

  always_comb begin
    instr_d = instr_q;
    ipc_d   = ipc_q;
    valid_d = valid_q;
    if (squash) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (if_id_write && imem.imem_valid && live) begin
      instr_d = imem.imem_rdata;
      ipc_d   = pc_q;
      valid_d = 1'b1;
    end else if (if_id_write && !imem.imem_valid) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end
  end

  assign err_d = err_q | (branch_taken && misaligned(branch_target[1:0]));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      ipc_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      if (branch_taken) begin
        state_q <= RUN;
      end else begin
        unique case (state_q)
          BOOT:    state_q <= RUN;
          // Only a wanted fetch that memory cannot serve counts as a miss.
          RUN:     state_q <= (pc_write && !imem.imem_valid) ? MISS : RUN;
          MISS:    state_q <= imem.imem_valid ? RUN : MISS;
          default: state_q <= BOOT;
        endcase
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc),
    .clr   (1'b0),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (squash),
    .clr   (1'b0),
    .count (flush_cnt)
  );

  assign imem.imem_addr = pc_q;
  assign if_id_instr    = instr_q;
  assign if_id_pc       = ipc_q;
  assign if_id_valid    = valid_q;
  assign fetch_state    = state_q;
  assign misalign_err   = err_q;

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// Directed bench for fetch_stage_ctrl: a per-cycle vector table plus
// hand-written sequences for sticky error, async reset and counter saturation.
module tb_fetch_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pc_write = 1'b0;
  logic        if_id_write = 1'b0;
  logic        if_flush = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        iv = 1'b0;
  logic [31:0] rd = '0;

  logic [31:0] instr1, ipc1, instr2, ipc2;
  logic        valid1, valid2, err1, err2;
  logic [1:0]  st1, st2;
  logic [15:0] sc1, fc1;
  logic [3:0]  sc2, fc2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_stage_ctrl_if #(.XLEN(32)) bus1 ();
  fetch_stage_ctrl_if #(.XLEN(32)) bus2 ();
  assign bus1.imem_valid = iv;
  assign bus1.imem_rdata = rd;
  assign bus2.imem_valid = iv;
  assign bus2.imem_rdata = rd;

  fetch_stage_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .pc_write(pc_write), .if_id_write(if_id_write),
    .if_flush(if_flush), .branch_taken(branch_taken), .branch_target(branch_target),
    .imem(bus1), .if_id_instr(instr1), .if_id_pc(ipc1), .if_id_valid(valid1),
    .fetch_state(st1), .stall_cnt(sc1), .flush_cnt(fc1), .misalign_err(err1)
  );

  fetch_stage_ctrl #(.CNT_W(4)) dut_small (
    .clk(clk), .rst_n(rst_n), .pc_write(pc_write), .if_id_write(if_id_write),
    .if_flush(if_flush), .branch_taken(branch_taken), .branch_target(branch_target),
    .imem(bus2), .if_id_instr(instr2), .if_id_pc(ipc2), .if_id_valid(valid2),
    .fetch_state(st2), .stall_cnt(sc2), .flush_cnt(fc2), .misalign_err(err2)
  );

  typedef struct {
    logic        pw, iw, fl, br;
    logic [31:0] tgt;
    logic        iv;
    logic [31:0] rd;
    logic [31:0] addr, instr, ipc;
    logic        v;
    logic [1:0]  st;
    logic [15:0] sc, fc;
    logic        err;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs[NV];

  function automatic vec_t mk(logic pw, logic iw, logic fl, logic br, logic [31:0] tgt,
                              logic v_in, logic [31:0] rdata, logic [31:0] addr,
                              logic [31:0] instr, logic [31:0] ipc, logic v,
                              logic [1:0] st, logic [15:0] sc, logic [15:0] fc, logic err);
    vec_t r;
    r.pw = pw; r.iw = iw; r.fl = fl; r.br = br; r.tgt = tgt; r.iv = v_in; r.rd = rdata;
    r.addr = addr; r.instr = instr; r.ipc = ipc; r.v = v; r.st = st;
    r.sc = sc; r.fc = fc; r.err = err;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic pw, input logic iw, input logic fl, input logic br,
                       input logic [31:0] tgt, input logic v_in, input logic [31:0] rdata);
    pc_write = pw; if_id_write = iw; if_flush = fl; branch_taken = br;
    branch_target = tgt; iv = v_in; rd = rdata;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ".addr"},  bus1.imem_addr, 32'h0);
    chk({tag, ".instr"}, instr1, 32'h0000_0013);
    chk({tag, ".ipc"},   ipc1, 32'h0);
    chk({tag, ".valid"}, {31'b0, valid1}, 32'h0);
    chk({tag, ".state"}, {30'b0, st1}, 32'h0);
    chk({tag, ".stall"}, {16'b0, sc1}, 32'h0);
    chk({tag, ".flush"}, {16'b0, fc1}, 32'h0);
    chk({tag, ".err"},   {31'b0, err1}, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    //                pw iw fl br tgt           iv rd            | addr          instr         ipc           v  st sc fc err
    vecs[0]  = mk(1, 1, 0, 0, 32'h0,        1, 32'h1111_0000, 32'h0,        32'h13,       32'h0,        0, 1, 0, 0, 0);
    vecs[1]  = mk(1, 1, 0, 0, 32'h0,        1, 32'hA000_0000, 32'h4,        32'hA000_0000,32'h0,        1, 1, 0, 0, 0);
    vecs[2]  = mk(1, 1, 0, 0, 32'h0,        1, 32'hA000_0004, 32'h8,        32'hA000_0004,32'h4,        1, 1, 0, 0, 0);
    vecs[3]  = mk(1, 1, 0, 0, 32'h0,        1, 32'hA000_0008, 32'hC,        32'hA000_0008,32'h8,        1, 1, 0, 0, 0);
    vecs[4]  = mk(1, 1, 0, 0, 32'h0,        1, 32'hA000_000C, 32'h10,       32'hA000_000C,32'hC,        1, 1, 0, 0, 0);
    vecs[5]  = mk(0, 0, 0, 0, 32'h0,        1, 32'hB000_0010, 32'h10,       32'hA000_000C,32'hC,        1, 1, 1, 0, 0);
    vecs[6]  = mk(0, 0, 0, 0, 32'h0,        1, 32'hB000_0010, 32'h10,       32'hA000_000C,32'hC,        1, 1, 2, 0, 0);
    vecs[7]  = mk(0, 0, 1, 1, 32'h40,       1, 32'hB000_0010, 32'h40,       32'h13,       32'hC,        0, 1, 2, 1, 0);
    vecs[8]  = mk(1, 1, 0, 1, 32'h20,       1, 32'hB000_0040, 32'h20,       32'h13,       32'hC,        0, 1, 2, 2, 0);
    vecs[9]  = mk(1, 1, 0, 0, 32'h0,        0, 32'hDEAD_BEEF, 32'h20,       32'h13,       32'hC,        0, 2, 2, 2, 0);
    vecs[10] = mk(1, 1, 0, 0, 32'h0,        0, 32'hDEAD_BEEF, 32'h20,       32'h13,       32'hC,        0, 2, 2, 2, 0);
    vecs[11] = mk(1, 1, 0, 0, 32'h0,        0, 32'hDEAD_BEEF, 32'h20,       32'h13,       32'hC,        0, 2, 2, 2, 0);
    vecs[12] = mk(1, 1, 0, 0, 32'h0,        1, 32'hC0DE_0020, 32'h24,       32'hC0DE_0020,32'h20,       1, 1, 2, 2, 0);
    vecs[13] = mk(1, 1, 0, 0, 32'h0,        0, 32'hDEAD_BEEF, 32'h24,       32'h13,       32'h20,       0, 2, 2, 2, 0);
    vecs[14] = mk(1, 1, 0, 1, 32'h43,       0, 32'hDEAD_BEEF, 32'h40,       32'h13,       32'h20,       0, 1, 2, 3, 1);
    vecs[15] = mk(1, 1, 0, 0, 32'h0,        1, 32'h1234_0040, 32'h44,       32'h1234_0040,32'h40,       1, 1, 2, 3, 1);
    vecs[16] = mk(0, 0, 0, 1, 32'h100,      1, 32'h1234_0044, 32'h100,      32'h13,       32'h40,       0, 1, 2, 4, 1);
    vecs[17] = mk(0, 1, 0, 0, 32'h0,        0, 32'hDEAD_BEEF, 32'h100,      32'h13,       32'h40,       0, 1, 2, 4, 1);
    vecs[18] = mk(1, 1, 0, 1, 32'hFFFF_FFFC,1, 32'h5555_0100, 32'hFFFF_FFFC,32'h13,       32'h40,       0, 1, 2, 5, 1);
    vecs[19] = mk(1, 1, 0, 0, 32'h0,        1, 32'h7777_0000, 32'h0,        32'h7777_0000,32'hFFFF_FFFC,1, 1, 2, 5, 1);
    vecs[20] = mk(1, 1, 1, 0, 32'h0,        1, 32'h8888_0000, 32'h4,        32'h13,       32'hFFFF_FFFC,0, 1, 2, 6, 1);

    drive(0, 0, 0, 0, 32'h0, 1, 32'h0);
    rst_n = 1'b0;
    #22;
    rst_n = 1'b1;
    #1;
    chk_reset_state("reset");

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].pw, vecs[i].iw, vecs[i].fl, vecs[i].br, vecs[i].tgt, vecs[i].iv, vecs[i].rd);
      tick();
      chk($sformatf("v%0d.addr", i),  bus1.imem_addr, vecs[i].addr);
      chk($sformatf("v%0d.instr", i), instr1, vecs[i].instr);
      chk($sformatf("v%0d.ipc", i),   ipc1, vecs[i].ipc);
      chk($sformatf("v%0d.valid", i), {31'b0, valid1}, {31'b0, vecs[i].v});
      chk($sformatf("v%0d.state", i), {30'b0, st1}, {30'b0, vecs[i].st});
      chk($sformatf("v%0d.stall", i), {16'b0, sc1}, {16'b0, vecs[i].sc});
      chk($sformatf("v%0d.flush", i), {16'b0, fc1}, {16'b0, vecs[i].fc});
      chk($sformatf("v%0d.err", i),   {31'b0, err1}, {31'b0, vecs[i].err});
    end

    // Sticky misalign flag survives ten more normal fetches.
    drive(1, 1, 0, 0, 32'h0, 1, 32'h9999_0000);
    for (int i = 0; i < 10; i++) tick();
    chk("sticky.err",  {31'b0, err1}, 32'h1);
    chk("sticky.addr", bus1.imem_addr, 32'h2C);

    // Asynchronous reset mid-cycle, checked before any clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_state("async");
    chk("async.small_err", {31'b0, err2}, 32'h0);
    #2;
    rst_n = 1'b1;

    // Long load-use stall: the 4-bit counters stick at 15, the 16-bit keep counting.
    drive(0, 0, 0, 0, 32'h0, 1, 32'h0);
    for (int i = 0; i < 14; i++) tick();
    chk("sat14.small", {28'b0, sc2}, 32'd14);
    for (int i = 0; i < 6; i++) tick();
    chk("sat20.small", {28'b0, sc2}, 32'd15);
    chk("sat20.wide",  {16'b0, sc1}, 32'd20);
    chk("sat20.flush", {28'b0, fc2}, 32'd0);
    chk("sat20.addr",  bus1.imem_addr, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
